// File: rtl/ser_fifo_pkg.sv
// Shared types and helpers for the word-in / bit-out Tx FIFO.
package ser_fifo_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } ser_state_t;

  // Occupancy from wrap-bit pointers; the mask keeps the modulo at ptrBits.
  function automatic logic [31:0] fifoLevel(
    input logic [31:0] wrPtr,
    input logic [31:0] rdPtr,
    input int unsigned ptrBits
  );
    logic [31:0] mask;
    mask = (32'd1 << ptrBits) - 32'd1;
    return (wrPtr - rdPtr) & mask;
  endfunction

endpackage

// File: rtl/ser_fifo_if.sv
// Producer word handshake, serial bit handshake, control and status of ser_fifo.
interface ser_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 7
);

  logic                  inWriteValid;
  logic [DATA_WIDTH-1:0] inData;
  logic                  outWriteReady;
  logic                  inBitReady;
  logic                  outBitValid;
  logic                  outBit;
  logic                  outSymbolStart;
  logic                  inFlush;
  logic                  inClearErrors;
  logic [DEPTH_LOG2:0]   outLevel;
  logic                  outFull;
  logic                  outEmpty;
  logic                  outAlmostFull;
  logic                  outAlmostEmpty;
  logic                  outWriteError;
  logic                  outReadError;

  modport master (
    output inWriteValid, inData, inBitReady, inFlush, inClearErrors,
    input  outWriteReady, outBitValid, outBit, outSymbolStart, outLevel,
           outFull, outEmpty, outAlmostFull, outAlmostEmpty,
           outWriteError, outReadError
  );

  modport slave (
    input  inWriteValid, inData, inBitReady, inFlush, inClearErrors,
    output outWriteReady, outBitValid, outBit, outSymbolStart, outLevel,
           outFull, outEmpty, outAlmostFull, outAlmostEmpty,
           outWriteError, outReadError
  );

endinterface

// File: rtl/ser_fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read (distributed RAM).
module ser_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 7
) (
  input  logic                  inClock,
  input  logic                  inWriteEnable,
  input  logic [DEPTH_LOG2-1:0] inWriteAddr,
  input  logic [DATA_WIDTH-1:0] inWriteData,
  input  logic [DEPTH_LOG2-1:0] inReadAddr,
  output logic [DATA_WIDTH-1:0] outReadData
);

  logic [DATA_WIDTH-1:0] memArray [0:(1 << DEPTH_LOG2)-1];

  always_ff @(posedge inClock) begin
    if (inWriteEnable) begin
      memArray[inWriteAddr] <= inWriteData;
    end
  end

  // Read is combinational so a pop can load the shifter on the same edge.
  assign outReadData = memArray[inReadAddr];

endmodule

// File: rtl/ser_fifo.sv
// Word-in / bit-out FIFO: wrap-bit pointers, level flags, sticky errors and
// a two-state serializer that reloads on the last bit without a bubble.
module ser_fifo
  import ser_fifo_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int DEPTH_LOG2      = 7,
  parameter int MSB_FIRST       = 0,
  parameter int ALMOST_EMPTY_TH = (1 << DEPTH_LOG2) / 4,
  parameter int ALMOST_FULL_TH  = 3 * (1 << DEPTH_LOG2) / 4
) (
  input logic      inClock,
  input logic      inReset,
  ser_fifo_if.slave bus
);

  localparam int PTR_W   = DEPTH_LOG2 + 1;
  localparam int CNT_W   = $clog2(DATA_WIDTH);
  localparam int OUT_IDX = (MSB_FIRST != 0) ? DATA_WIDTH - 1 : 0;

  logic [PTR_W-1:0]      wrPtrReg;
  logic [PTR_W-1:0]      rdPtrReg;
  logic [PTR_W-1:0]      level;
  logic                  full;
  logic                  empty;
  ser_state_t            stateReg;
  logic [DATA_WIDTH-1:0] shiftReg;
  logic [CNT_W-1:0]      bitCntReg;
  logic [DATA_WIDTH-1:0] memRdData;
  logic                  writeErrReg;
  logic                  readErrReg;
  logic                  writeAccept;
  logic                  advance;
  logic                  lastBit;
  logic                  popNow;

  assign level = PTR_W'(fifoLevel(32'(wrPtrReg), 32'(rdPtrReg), PTR_W));
  assign full  = (level == PTR_W'(1 << DEPTH_LOG2));
  assign empty = (level == '0);

  // Full is judged before the edge: a simultaneous pop does not make room.
  assign writeAccept = bus.inWriteValid && !full && !bus.inFlush;
  assign advance     = (stateReg == S_SHIFT) && bus.inBitReady;
  assign lastBit     = (bitCntReg == CNT_W'(DATA_WIDTH - 1));
  assign popNow      = !bus.inFlush && !empty &&
                       ((stateReg == S_IDLE) || (advance && lastBit));

  ser_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .inClock      (inClock),
    .inWriteEnable(writeAccept),
    .inWriteAddr  (wrPtrReg[DEPTH_LOG2-1:0]),
    .inWriteData  (bus.inData),
    .inReadAddr   (rdPtrReg[DEPTH_LOG2-1:0]),
    .outReadData  (memRdData)
  );

  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
    end else begin
      if (writeAccept) begin
        wrPtrReg <= wrPtrReg + PTR_W'(1);
      end
      if (bus.inFlush) begin
        rdPtrReg <= wrPtrReg;
      end else if (popNow) begin
        rdPtrReg <= rdPtrReg + PTR_W'(1);
      end
    end
  end

  // Shifted-out positions fill with zero, so an idle shifter rests at 0.
  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) begin
      stateReg  <= S_IDLE;
      shiftReg  <= '0;
      bitCntReg <= '0;
    end else if (bus.inFlush) begin
      stateReg  <= S_IDLE;
      shiftReg  <= '0;
      bitCntReg <= '0;
    end else begin
      case (stateReg)
        S_IDLE: begin
          if (popNow) begin
            shiftReg  <= memRdData;
            bitCntReg <= '0;
            stateReg  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (bus.inBitReady) begin
            if (lastBit) begin
              bitCntReg <= '0;
              if (popNow) begin
                shiftReg <= memRdData;
              end else begin
                shiftReg <= '0;
                stateReg <= S_IDLE;
              end
            end else begin
              bitCntReg <= bitCntReg + CNT_W'(1);
              shiftReg  <= (MSB_FIRST != 0) ? (shiftReg << 1) : (shiftReg >> 1);
            end
          end
        end
        default: stateReg <= S_IDLE;
      endcase
    end
  end

  // Set beats clear on the same edge; flush leaves both flags alone.
  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) begin
      writeErrReg <= 1'b0;
      readErrReg  <= 1'b0;
    end else begin
      writeErrReg <= (writeErrReg && !bus.inClearErrors) ||
                     (bus.inWriteValid && full);
      readErrReg  <= (readErrReg && !bus.inClearErrors) ||
                     (bus.inBitReady && (stateReg != S_SHIFT));
    end
  end

  assign bus.outWriteReady  = !full;
  assign bus.outBitValid    = (stateReg == S_SHIFT);
  assign bus.outBit         = shiftReg[OUT_IDX];
  assign bus.outSymbolStart = (stateReg == S_SHIFT) && (bitCntReg == '0);
  assign bus.outLevel       = level;
  assign bus.outFull        = full;
  assign bus.outEmpty       = empty;
  assign bus.outAlmostFull  = (level >= PTR_W'(ALMOST_FULL_TH));
  assign bus.outAlmostEmpty = (level <= PTR_W'(ALMOST_EMPTY_TH));
  assign bus.outWriteError  = writeErrReg;
  assign bus.outReadError   = readErrReg;

endmodule

// File: tb/tb_ser_fifo.sv
// Random and directed checks of two ser_fifo instances (LSB-first and MSB-first)
// against a queue-based reference model of the FIFO and serializer.
module tb_ser_fifo;

  logic       inClock;
  logic       inReset;
  logic       wv;
  logic [7:0] wData;
  logic       br;
  logic       flush;
  logic       clr;

  int checkCount;
  int passCount;

  ser_fifo_if #(.DATA_WIDTH(8), .DEPTH_LOG2(3)) busL ();
  ser_fifo_if #(.DATA_WIDTH(8), .DEPTH_LOG2(3)) busM ();

  assign busL.inWriteValid  = wv;
  assign busL.inData        = wData;
  assign busL.inBitReady    = br;
  assign busL.inFlush       = flush;
  assign busL.inClearErrors = clr;
  assign busM.inWriteValid  = wv;
  assign busM.inData        = wData;
  assign busM.inBitReady    = br;
  assign busM.inFlush       = flush;
  assign busM.inClearErrors = clr;

  ser_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(3), .MSB_FIRST(0)) dutLsb (
    .inClock(inClock), .inReset(inReset), .bus(busL)
  );
  ser_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(3), .MSB_FIRST(1)) dutMsb (
    .inClock(inClock), .inReset(inReset), .bus(busM)
  );

  initial inClock = 1'b0;
  always #5 inClock = ~inClock;

  // Reference model: a word queue, the symbol being sent and its bit index.
  logic [7:0] q[$];
  bit         busy;
  int         bitIdx;
  logic [7:0] cur;
  bit         wErr;
  bit         rErr;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end else begin
      passCount++;
    end
  endtask

  task automatic modelReset();
    q.delete();
    busy   = 1'b0;
    bitIdx = 0;
    cur    = 8'h00;
    wErr   = 1'b0;
    rErr   = 1'b0;
  endtask

  task automatic modelEdge();
    int lvl;
    bit isFull;
    bit isEmpty;
    bit setW;
    bit setR;
    bit doPop;
    lvl     = q.size();
    isFull  = (lvl == 8);
    isEmpty = (lvl == 0);
    setW    = wv && isFull;
    setR    = br && !busy;
    doPop   = 1'b0;
    if (flush) begin
      q.delete();
      busy   = 1'b0;
      bitIdx = 0;
    end else begin
      if (!busy) begin
        doPop = !isEmpty;
      end else if (br) begin
        if (bitIdx == 7) begin
          if (!isEmpty) doPop = 1'b1;
          else busy = 1'b0;
        end else begin
          bitIdx++;
        end
      end
      if (doPop) begin
        cur    = q.pop_front();
        busy   = 1'b1;
        bitIdx = 0;
        $display("pop  symbol=0x%02h queued=%0d t=%0t", cur, q.size(), $time);
      end
      if (wv && !isFull) q.push_back(wData);
    end
    wErr = (wErr && !clr) || setW;
    rErr = (rErr && !clr) || setR;
  endtask

  task automatic checkAll();
    int lvl;
    lvl = q.size();
    checkVal("level",        32'(busL.outLevel),       32'(lvl));
    checkVal("empty",        32'(busL.outEmpty),       32'(lvl == 0));
    checkVal("full",         32'(busL.outFull),        32'(lvl == 8));
    checkVal("almost_empty", 32'(busL.outAlmostEmpty), 32'(lvl <= 2));
    checkVal("almost_full",  32'(busL.outAlmostFull),  32'(lvl >= 6));
    checkVal("write_ready",  32'(busL.outWriteReady),  32'(lvl != 8));
    checkVal("bit_valid",    32'(busL.outBitValid),    32'(busy));
    checkVal("sym_start",    32'(busL.outSymbolStart), 32'(busy && bitIdx == 0));
    checkVal("write_error",  32'(busL.outWriteError),  32'(wErr));
    checkVal("read_error",   32'(busL.outReadError),   32'(rErr));
    checkVal("msb_level",    32'(busM.outLevel),       32'(lvl));
    checkVal("msb_valid",    32'(busM.outBitValid),    32'(busy));
    checkVal("msb_start",    32'(busM.outSymbolStart), 32'(busy && bitIdx == 0));
    if (busy) begin
      checkVal("lsb_bit", 32'(busL.outBit), 32'(cur[bitIdx]));
      checkVal("msb_bit", 32'(busM.outBit), 32'(cur[7 - bitIdx]));
    end
  endtask

  task automatic step(input bit iWv, input logic [7:0] iData, input bit iBr,
                      input bit iFlush, input bit iClr);
    wv    = iWv;
    wData = iData;
    br    = iBr;
    flush = iFlush;
    clr   = iClr;
    @(posedge inClock);
    modelEdge();
    #1;
    checkAll();
  endtask

  task automatic checkResetValues(input string tag);
    checkVal({tag, "_level"},   32'(busL.outLevel),       32'd0);
    checkVal({tag, "_empty"},   32'(busL.outEmpty),       32'd1);
    checkVal({tag, "_aempty"},  32'(busL.outAlmostEmpty), 32'd1);
    checkVal({tag, "_wready"},  32'(busL.outWriteReady),  32'd1);
    checkVal({tag, "_full"},    32'(busL.outFull),        32'd0);
    checkVal({tag, "_afull"},   32'(busL.outAlmostFull),  32'd0);
    checkVal({tag, "_valid"},   32'(busL.outBitValid),    32'd0);
    checkVal({tag, "_bit"},     32'(busL.outBit),         32'd0);
    checkVal({tag, "_mbit"},    32'(busM.outBit),         32'd0);
    checkVal({tag, "_start"},   32'(busL.outSymbolStart), 32'd0);
    checkVal({tag, "_werr"},    32'(busL.outWriteError),  32'd0);
    checkVal({tag, "_rerr"},    32'(busL.outReadError),   32'd0);
  endtask

  // Clock bits out until the model is idle; an expired budget is a failure.
  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((busy || q.size() != 0) && n < 200) begin
      step(1'b0, 8'h00, busy, 1'b0, 1'b0);
      n++;
    end
    checkVal({tag, "_drained"}, 32'(busy || q.size() != 0), 32'd0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [7:0]  bitsL;
    logic [7:0]  startsL;
    logic [15:0] bitsM;
    logic [15:0] startsM;
    logic        allValid;

    checkCount = 0;
    passCount  = 0;
    inReset = 1'b0;
    wv = 1'b0; wData = 8'h00; br = 1'b0; flush = 1'b0; clr = 1'b0;
    modelReset();
    repeat (3) @(negedge inClock);
    inReset = 1'b1;
    #1;
    checkResetValues("reset");

    // 1: single LSB-first symbol, bit ready only while a bit is offered
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    checkVal("t1_not_yet_valid", 32'(busL.outBitValid), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkVal("t1_valid_after_pop", 32'(busL.outBitValid), 32'd1);
    for (int i = 0; i < 8; i++) begin
      bitsL[i]   = busL.outBit;
      startsL[i] = busL.outSymbolStart;
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    checkVal("t1_bits",   32'(bitsL),   32'h0000_00A5);
    checkVal("t1_starts", 32'(startsL), 32'h0000_0001);
    checkVal("t1_empty_after",  32'(busL.outEmpty),    32'd1);
    checkVal("t1_valid_after",  32'(busL.outBitValid), 32'd0);

    // 2: back-to-back symbols, MSB-first stream
    step(1'b1, 8'h81, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h7E, 1'b0, 1'b0, 1'b0);
    allValid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bitsM[15 - i]   = busM.outBit;
      startsM[15 - i] = busM.outSymbolStart;
      allValid        = allValid & busM.outBitValid;
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    checkVal("t2_bits",     32'(bitsM),    32'h0000_817E);
    checkVal("t2_starts",   32'(startsM),  32'h0000_8080);
    checkVal("t2_no_gap",   32'(allValid), 32'd1);
    checkVal("t2_idle",     32'(busM.outBitValid), 32'd0);

    // 3: fill (one word sits in the shifter), overflow, drain, refill across wrap
    for (int i = 0; i < 9; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    checkVal("t3_full",   32'(busL.outFull),       32'd1);
    checkVal("t3_level",  32'(busL.outLevel),      32'd8);
    checkVal("t3_wready", 32'(busL.outWriteReady), 32'd0);
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    checkVal("t3_overflow", 32'(busL.outWriteError), 32'd1);
    drain("t3a");
    for (int i = 0; i < 9; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    checkVal("t3_refull", 32'(busL.outFull), 32'd1);
    drain("t3b");

    // 4: simultaneous write and pop at level 2, then threshold at level 3
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    checkVal("t4_level2",  32'(busL.outLevel),       32'd2);
    checkVal("t4_aempty2", 32'(busL.outAlmostEmpty), 32'd1);
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b1, 1'b0, 1'b0);
    checkVal("t4_level_kept", 32'(busL.outLevel), 32'd2);
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    checkVal("t4_level3",  32'(busL.outLevel),       32'd3);
    checkVal("t4_aempty3", 32'(busL.outAlmostEmpty), 32'd0);
    drain("t4");

    // 5: underrun, clear colliding with a new underrun, then clear alone
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkVal("t5_underrun", 32'(busL.outReadError), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    checkVal("t5_set_wins", 32'(busL.outReadError), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkVal("t5_cleared",  32'(busL.outReadError), 32'd0);

    // 6: flush mid-symbol with three words queued, then async reset mid-cycle
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkVal("t6_queued", 32'(busL.outLevel), 32'd3);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkVal("t6_flush_valid", 32'(busL.outBitValid),  32'd0);
    checkVal("t6_flush_level", 32'(busL.outLevel),     32'd0);
    checkVal("t6_flush_rerr",  32'(busL.outReadError), 32'd1);
    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    #2;
    inReset = 1'b0;
    #1;
    checkResetValues("async");
    wv = 1'b0; br = 1'b0; flush = 1'b0; clr = 1'b0;
    modelReset();
    @(negedge inClock);
    inReset = 1'b1;

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) == 0, $urandom_range(0, 49) == 0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
